// File: rtl/multi_pulse_det_pkg.sv
// Shared defaults and helpers for multi_pulse_detector and its per-channel slice.
// The optional input synchroniser is enabled by defining MULTI_PULSE_DET_SYNC_EN.
package multi_pulse_det_pkg;

   localparam int DEF_N          = 4;
   localparam int DEF_MIN_LEN    = 1;
   localparam int DEF_MAX_LEN    = 1;
   localparam int DEF_ACTIVE_LOW = 0;
   localparam int DEF_EVT_W      = 8;

   // One extra code above MAX_LEN marks a run that is already too long.
   function automatic int cnt_width(input int max_len);
      return $clog2(max_len + 2);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
      return (value >= limit) ? limit : value + 32'd1;
   endfunction

endpackage

// File: rtl/multi_pulse_det_channel.sv
// One channel: edge flags, run-length qualification and saturating event count.
// MULTI_PULSE_DET_SYNC_EN inserts a two-flop synchroniser in front of the logic.
module multi_pulse_det_channel
   import multi_pulse_det_pkg::*;
#(
   parameter int MIN_LEN    = DEF_MIN_LEN,
   parameter int MAX_LEN    = DEF_MAX_LEN,
   parameter int ACTIVE_LOW = DEF_ACTIVE_LOW,
   parameter int EVT_W      = DEF_EVT_W,
   parameter int CNT_W      = cnt_width(MAX_LEN)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             clr,
   output logic             rise,
   output logic             fall,
   output logic             detected,
   output logic [CNT_W-1:0] pulse_len,
   output logic [EVT_W-1:0] evt_cnt
);

   localparam logic             INACTIVE = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_LEN + 1);
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_LEN);
   localparam logic [EVT_W-1:0] EVT_SAT  = '1;

   logic             a_s;
   logic             a_r;
   logic             act;
   logic             act_r;
   logic             pulse_end;
   logic [CNT_W-1:0] cnt;

`ifdef MULTI_PULSE_DET_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= {2{INACTIVE}};
      else     sync <= {sync[0], a};
   end

   assign a_s = sync[1];
`else
   assign a_s = a;
`endif

   // cnt holds the length of the current active run, parked at MAX_LEN+1 once too long.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r <= INACTIVE;
         cnt <= '0;
      end else begin
         a_r <= a_s;
         if (act) cnt <= CNT_W'(sat_inc(32'(cnt), 32'(CNT_SAT)));
         else     cnt <= '0;
      end
   end

   assign act       = a_s ^ INACTIVE;
   assign act_r     = a_r ^ INACTIVE;
   assign rise      = a_s & ~a_r;
   assign fall      = ~a_s & a_r;
   assign pulse_end = act_r & ~act;
   assign detected  = pulse_end && (cnt >= MIN_C) && (cnt <= MAX_C);
   assign pulse_len = detected ? cnt : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           evt_cnt <= '0;
      else if (clr)      evt_cnt <= '0;
      else if (detected) evt_cnt <= EVT_W'(sat_inc(32'(evt_cnt), 32'(EVT_SAT)));
   end

endmodule

// File: rtl/multi_pulse_detector.sv
// N independent edge / pulse-width detector channels with packed output vectors.
// Define MULTI_PULSE_DET_SYNC_EN to synchronise every input (adds 2 cycles latency).
module multi_pulse_detector
   import multi_pulse_det_pkg::*;
#(
   parameter  int N          = DEF_N,
   parameter  int MIN_LEN    = DEF_MIN_LEN,
   parameter  int MAX_LEN    = DEF_MAX_LEN,
   parameter  int ACTIVE_LOW = DEF_ACTIVE_LOW,
   parameter  int EVT_W      = DEF_EVT_W,
   localparam int CNT_W      = cnt_width(MAX_LEN)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       a,
   input  logic               clr,
   output logic [N-1:0]       rise,
   output logic [N-1:0]       fall,
   output logic [N-1:0]       detected,
   output logic [N*CNT_W-1:0] pulse_len,
   output logic [N*EVT_W-1:0] evt_cnt
);

   for (genvar i = 0; i < N; i++) begin : g_ch
      multi_pulse_det_channel #(
         .MIN_LEN    (MIN_LEN),
         .MAX_LEN    (MAX_LEN),
         .ACTIVE_LOW (ACTIVE_LOW),
         .EVT_W      (EVT_W),
         .CNT_W      (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .a         (a[i]),
         .clr       (clr),
         .rise      (rise[i]),
         .fall      (fall[i]),
         .detected  (detected[i]),
         .pulse_len (pulse_len[i*CNT_W +: CNT_W]),
         .evt_cnt   (evt_cnt[i*EVT_W +: EVT_W])
      );
   end

endmodule

// File: tb/tb_multi_pulse_detector.sv
// Directed bench: five differently configured instances exercise the 010 case, length window,
// active-low polarity, multi-channel/saturating counts and reset abort.
module tb_multi_pulse_detector;

`ifdef MULTI_PULSE_DET_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic rst_e;
   logic clr;

   logic       a_a, a_b, a_c, a_e;
   logic [3:0] a_d;

   logic       rise_a, fall_a, det_a;
   logic [1:0] plen_a;
   logic [7:0] evt_a;

   logic       rise_b, fall_b, det_b;
   logic [2:0] plen_b;
   logic [7:0] evt_b;

   logic       rise_c, fall_c, det_c;
   logic [1:0] plen_c;
   logic [7:0] evt_c;

   logic [3:0] rise_d, fall_d, det_d;
   logic [7:0] plen_d;
   logic [7:0] evt_d;

   logic       rise_e, fall_e, det_e;
   logic [1:0] plen_e;
   logic [7:0] evt_e;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_pulse_detector #(.N(1), .MIN_LEN(1), .MAX_LEN(1), .ACTIVE_LOW(0), .EVT_W(8)) dut_a (
      .clk(clk), .rst(rst), .a(a_a), .clr(clr), .rise(rise_a), .fall(fall_a),
      .detected(det_a), .pulse_len(plen_a), .evt_cnt(evt_a));

   multi_pulse_detector #(.N(1), .MIN_LEN(2), .MAX_LEN(3), .ACTIVE_LOW(0), .EVT_W(8)) dut_b (
      .clk(clk), .rst(rst), .a(a_b), .clr(clr), .rise(rise_b), .fall(fall_b),
      .detected(det_b), .pulse_len(plen_b), .evt_cnt(evt_b));

   multi_pulse_detector #(.N(1), .MIN_LEN(1), .MAX_LEN(1), .ACTIVE_LOW(1), .EVT_W(8)) dut_c (
      .clk(clk), .rst(rst), .a(a_c), .clr(clr), .rise(rise_c), .fall(fall_c),
      .detected(det_c), .pulse_len(plen_c), .evt_cnt(evt_c));

   multi_pulse_detector #(.N(4), .MIN_LEN(1), .MAX_LEN(1), .ACTIVE_LOW(0), .EVT_W(2)) dut_d (
      .clk(clk), .rst(rst), .a(a_d), .clr(clr), .rise(rise_d), .fall(fall_d),
      .detected(det_d), .pulse_len(plen_d), .evt_cnt(evt_d));

   multi_pulse_detector #(.N(1), .MIN_LEN(2), .MAX_LEN(2), .ACTIVE_LOW(0), .EVT_W(8)) dut_e (
      .clk(clk), .rst(rst_e), .a(a_e), .clr(clr), .rise(rise_e), .fall(fall_e),
      .detected(det_e), .pulse_len(plen_e), .evt_cnt(evt_e));

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic [3:0] value);
      case (sel)
         0: a_a = value[0];
         1: a_b = value[0];
         2: a_c = value[0];
         3: a_d = value;
         default: a_e = value[0];
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Vectors are MSB-first (bit 15 = first cycle); pulse_len uses one nibble per cycle.
   task automatic runSeq(input int sel, input string name, input int len, input logic pad,
                         input logic [15:0] av, input logic [15:0] rv, input logic [15:0] fv,
                         input logic [15:0] dv, input logic [63:0] pv);
      logic [31:0] o_r, o_f, o_d, o_p;
      for (int k = 0; k < len + LAT; k++) begin
         applyStimulus(sel, {3'b000, (k < len) ? av[15-k] : pad});
         @(negedge clk);
         if (k >= LAT) begin
            case (sel)
               0:       begin o_r = 32'(rise_a); o_f = 32'(fall_a); o_d = 32'(det_a); o_p = 32'(plen_a); end
               1:       begin o_r = 32'(rise_b); o_f = 32'(fall_b); o_d = 32'(det_b); o_p = 32'(plen_b); end
               default: begin o_r = 32'(rise_c); o_f = 32'(fall_c); o_d = 32'(det_c); o_p = 32'(plen_c); end
            endcase
            checkOutput($sformatf("%s_rise[%0d]", name, k - LAT), o_r, 32'(rv[15-(k-LAT)]));
            checkOutput($sformatf("%s_fall[%0d]", name, k - LAT), o_f, 32'(fv[15-(k-LAT)]));
            checkOutput($sformatf("%s_det[%0d]",  name, k - LAT), o_d, 32'(dv[15-(k-LAT)]));
            checkOutput($sformatf("%s_plen[%0d]", name, k - LAT), o_p, 32'(pv[63-4*(k-LAT) -: 4]));
         end
         step();
      end
   endtask

   initial begin
      rst   = 1'b1;
      rst_e = 1'b1;
      clr   = 1'b0;
      a_a   = 1'b0;
      a_b   = 1'b0;
      a_c   = 1'b1;
      a_d   = 4'b0000;
      a_e   = 1'b0;
      repeat (3) step();
      rst   = 1'b0;
      rst_e = 1'b0;

      @(negedge clk);
      checkOutput("reset_rise_a", 32'(rise_a), 32'd0);
      checkOutput("reset_fall_a", 32'(fall_a), 32'd0);
      checkOutput("reset_det_a",  32'(det_a),  32'd0);
      checkOutput("reset_plen_a", 32'(plen_a), 32'd0);
      checkOutput("reset_evt_a",  32'(evt_a),  32'd0);
      checkOutput("reset_det_c",  32'(det_c),  32'd0);
      checkOutput("reset_rise_c", 32'(rise_c), 32'd0);
      checkOutput("reset_det_d",  32'(det_d),  32'd0);
      checkOutput("reset_evt_d",  32'(evt_d),  32'd0);
      checkOutput("reset_plen_d", 32'(plen_d), 32'd0);
      step();

      $display("[TB] 010 detector, a=1001011011110001");
      runSeq(0, "p010", 16, 1'b0, 16'b1001011011110001, 16'b1001010010000001,
             16'b0100100100001000, 16'b0100100000000000, 64'h0100_1000_0000_0000);

      $display("[TB] window 2..3");
      runSeq(1, "win", 16, 1'b0, 16'b0101101110111100, 16'b0101001000100000,
             16'b0010010001000010, 16'b0000010001000000, 64'h0000_0200_0300_0000);

      $display("[TB] active-low 010");
      runSeq(2, "alow", 4, 1'b1, 16'b1011111111111111, 16'h2000, 16'h4000, 16'h2000,
             64'h0010_0000_0000_0000);

      $display("[TB] simultaneous channels 0 and 3");
      applyStimulus(3, 4'b1001);
      step();
      applyStimulus(3, 4'b0000);
      repeat (LAT) step();
      @(negedge clk);
      checkOutput("multi_det",  32'(det_d),  32'h9);
      checkOutput("multi_plen", 32'(plen_d), 32'h41);
      step();
      @(negedge clk);
      checkOutput("multi_evt", 32'(evt_d), 32'h41);
      checkOutput("multi_det_after", 32'(det_d), 32'h0);
      step();

      $display("[TB] 2-bit event counter saturation");
      clr = 1'b1;
      step();
      clr = 1'b0;
      @(negedge clk);
      checkOutput("clr_evt", 32'(evt_d), 32'h0);
      step();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(3, 4'b0001);
         step();
         applyStimulus(3, 4'b0000);
         repeat (LAT) step();
         step();
         @(negedge clk);
         checkOutput($sformatf("sat_evt[%0d]", i), 32'(evt_d), (i < 2) ? 32'(i + 1) : 32'd3);
         step();
      end

      applyStimulus(3, 4'b0001);
      step();
      applyStimulus(3, 4'b0000);
      repeat (LAT) step();
      clr = 1'b1;
      @(negedge clk);
      checkOutput("clr_coinc_det", 32'(det_d), 32'h1);
      step();
      clr = 1'b0;
      @(negedge clk);
      checkOutput("clr_coinc_evt", 32'(evt_d), 32'h0);
      step();

      $display("[TB] reset mid-pulse");
      applyStimulus(4, 4'b0001);
      step();
      rst_e = 1'b1;
      @(negedge clk);
      checkOutput("rst_det",  32'(det_e),  32'd0);
      checkOutput("rst_plen", 32'(plen_e), 32'd0);
      checkOutput("rst_evt",  32'(evt_e),  32'd0);
      step();
      rst_e = 1'b0;
      step();
      applyStimulus(4, 4'b0000);
      repeat (LAT) step();
      @(negedge clk);
      checkOutput("abort_det",  32'(det_e),  32'd0);
      checkOutput("abort_plen", 32'(plen_e), 32'd0);
      step();
      @(negedge clk);
      checkOutput("abort_evt", 32'(evt_e), 32'd0);
      step();

      applyStimulus(4, 4'b0001);
      step();
      step();
      applyStimulus(4, 4'b0000);
      repeat (LAT) step();
      @(negedge clk);
      checkOutput("len2_det",  32'(det_e),  32'd1);
      checkOutput("len2_plen", 32'(plen_e), 32'd2);
      step();
      @(negedge clk);
      checkOutput("len2_evt", 32'(evt_e), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_pulse_detector.md
# multi_pulse_detector

- Parametrised, multi-channel edge and pulse-width detector for single-bit level signals.
- Per channel it flags rising and falling edges and qualifies each completed pulse by its length against a programmable [MIN_LEN, MAX_LEN] window.
- Per channel it also keeps a saturating count of qualified pulses.
- It is the general form of the 010 one-cycle-pulse detector (MIN_LEN = MAX_LEN = 1) and feeds interrupt/event logic downstream.

## Interface
- N, 4, number of independent channels (≥1)
- MIN_LEN, 1, shortest qualifying pulse in cycles (≥1)
- MAX_LEN, 1, longest qualifying pulse in cycles (≥MIN_LEN)
- ACTIVE_LOW, 0, 0: pulse = run of 1s; 1: pulse = run of 0s
- EVT_W, 8, event counter width per channel
- clk  input  1  clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- a  input  N  sampled level per channel
- clr  input  1  synchronous clear of all event counters
- rise  output  N  a 0→1 transition this cycle
- fall  output  N  a 1→0 transition this cycle
- detected  output  N  a qualifying pulse ended this cycle
- pulse_len  output  N*CNT_W  length of the ended pulse, channel i at [i*CNT_W +: CNT_W]
- evt_cnt  output  N*EVT_W  qualified pulses since reset/clr

## Operation
- Register a_r: previous sample, reset to the inactive level (0, or 1 when ACTIVE_LOW).
- Edges are combinational on the current a vs a_r: rise = a & ~a_r, fall = ~a & a_r. Edges are polarity-independent.
- Run counter cnt, CNT_W = $clog2(MAX_LEN+2) bits:
  - a active → cnt <= min(cnt+1, MAX_LEN+1)
  - a inactive → cnt <= 0
  - Saturating at MAX_LEN+1 encodes "too long"; the counter never wraps.
- Pulse end = a_r active & a inactive. At that cycle cnt equals the run length.
- detected = pulse end & MIN_LEN ≤ cnt ≤ MAX_LEN.
- pulse_len = cnt when detected, else 0.
- Reset leaves a_r inactive, so a pulse that starts in the first cycle after reset counts as preceded by the inactive level.
- evt_cnt[i] increments by 1 when detected[i], saturating at 2^EVT_W−1.
  - clr has priority: clr and detected in the same cycle → counter = 0.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.

## Timing
- rise/fall/detected/pulse_len are combinational from a and registered state. They are valid in the cycle a is presented and sampled by downstream logic on the next posedge.
- A pulse is reported in the first inactive cycle after it, i.e. one cycle after its last active cycle.
- evt_cnt is registered and updates on the posedge following detected.
- rst asserted mid-pulse aborts it: cnt = 0, a_r inactive, evt_cnt = 0. No detected is produced for the aborted pulse.
- Reset values: a_r = inactive, cnt = 0, evt_cnt = 0. With a held inactive, rise = fall = detected = 0 and pulse_len = 0.

## Configuration
- MULTI_PULSE_DET_SYNC_EN
  - Defined: a passes through a two-flop synchroniser per channel, reset to the inactive level, before edge/pulse logic. Every output is delayed by 2 cycles relative to a, and a is treated as asynchronous.
  - Undefined: a feeds the logic directly with 0 added latency, and a must be synchronous to clk.

## Structure
- Package multi_pulse_det_pkg holds:
  - default parameter constants
  - the CNT_W derivation function (clog2(MAX_LEN+2))
  - a saturating-increment helper
- Sub-module multi_pulse_det_channel implements one channel: optional synchroniser, a_r, cnt, evt_cnt and edge/qualify logic. The top generates N instances and packs the output vectors.

## Test plan
- N=1, MIN=MAX=1, ACTIVE_LOW=0, a = 1001011011110001 after reset → rise 1001010010000001, detected 0100100000000000, pulse_len 1 on detected cycles.
- MIN=2, MAX=3, a = 0 1 0 1 1 0 1 1 1 0 1 1 1 1 0 → detected only at the 0 after the 2-run and after the 3-run, with pulse_len 2 then 3. The 1-run and the 4-run are rejected; cnt saturates at 4.
- ACTIVE_LOW=1, MIN=MAX=1, a = 1 0 1 1 → detected at cycle 2 with pulse_len 1; rise and fall still follow raw level changes.
- N=4, identical 010 pulses on channels 0 and 3 in the same cycle → detected = 4'b1001, and evt_cnt of channels 0 and 3 each increment next cycle.
- EVT_W=2, five qualifying pulses → evt_cnt 1,2,3,3,3. clr coincident with a detected → 0.
- rst asserted mid-pulse (after 1 active cycle, MIN=MAX=2), then a continues active for 1 cycle and falls → no detected. With MULTI_PULSE_DET_SYNC_EN, the 010 case reports detected 2 cycles later.
